// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants for the I2C pad input front end
package i2c_pkg;

   localparam int   I2C_SPK_W       = 8;
   localparam int   I2C_SYNC_STAGES = 2;
   // Both I2C lines idle high through their pull-ups.
   localparam logic I2C_IDLE_LVL    = 1'b1;

endpackage

// File: rtl/i2c_glitch_filt.sv
// rtl/i2c_glitch_filt.sv - one-line synchroniser, spike filter and edge pulses
module i2c_glitch_filt
   import i2c_pkg::*;
#(
   parameter int SPK_W       = I2C_SPK_W,
   parameter int SYNC_STAGES = I2C_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [SPK_W-1:0] spklen,
   input  logic             pad_in,
   output logic             filt,
   output logic             fall,
   output logic             rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SPK_W-1:0]       cnt;
   logic                   prev;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // The synchroniser keeps running while disabled so re-enable sees a settled level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{I2C_IDLE_LVL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      end
   end

   // cnt counts consecutive cycles of disagreement; >= lets a lowered spklen commit at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt <= I2C_IDLE_LVL;
         prev <= I2C_IDLE_LVL;
         cnt  <= '0;
      end else if (!en) begin
         filt <= I2C_IDLE_LVL;
         prev <= I2C_IDLE_LVL;
         cnt  <= '0;
      end else begin
         prev <= filt;
         if (synced == filt) begin
            cnt <= '0;
         end else if (cnt >= spklen) begin
            filt <= synced;
            cnt  <= '0;
         end else begin
            cnt <= cnt + SPK_W'(1);
         end
      end
   end

   assign fall = prev & ~filt;
   assign rise = ~prev & filt;

endmodule

// File: rtl/i2c_pad_filter.sv
// rtl/i2c_pad_filter.sv - SCL/SDA conditioning, delayed edges, START/STOP and bus busy
module i2c_pad_filter
   import i2c_pkg::*;
#(
   parameter int SPK_W       = I2C_SPK_W,
   parameter int SYNC_STAGES = I2C_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i2c_en,
   input  logic [SPK_W-1:0] i2c_spklen,
   input  logic             scl_pad_in,
   input  logic             sda_pad_in,
   output logic             i_scl_in,
   output logic             i_sda_in,
   output logic             f_scl,
   output logic             r_scl,
   output logic             f_sda,
   output logic             r_sda,
   output logic [2:0]       f_scl_d,
   output logic [2:1]       r_scl_d,
   output logic             start_det,
   output logic             stop_det,
   output logic             bus_busy
);

   logic scl_prev;
   logic r_scl_d0;

   i2c_glitch_filt #(
      .SPK_W       (SPK_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_scl_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (i2c_en),
      .spklen (i2c_spklen),
      .pad_in (scl_pad_in),
      .filt   (i_scl_in),
      .fall   (f_scl),
      .rise   (r_scl)
   );

   i2c_glitch_filt #(
      .SPK_W       (SPK_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sda_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (i2c_en),
      .spklen (i2c_spklen),
      .pad_in (sda_pad_in),
      .filt   (i_sda_in),
      .fall   (f_sda),
      .rise   (r_sda)
   );

   // SCL must have been high before and after the SDA edge; a same-cycle SCL commit disqualifies it.
   assign start_det = f_sda & i_scl_in & scl_prev;
   assign stop_det  = r_sda & i_scl_in & scl_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_prev <= I2C_IDLE_LVL;
         f_scl_d  <= '0;
         r_scl_d0 <= 1'b0;
         r_scl_d  <= '0;
         bus_busy <= 1'b0;
      end else if (!i2c_en) begin
         scl_prev <= I2C_IDLE_LVL;
         f_scl_d  <= '0;
         r_scl_d0 <= 1'b0;
         r_scl_d  <= '0;
         bus_busy <= 1'b0;
      end else begin
         scl_prev <= i_scl_in;
         f_scl_d  <= {f_scl_d[1:0], f_scl};
         r_scl_d0 <= r_scl;
         r_scl_d  <= {r_scl_d[1], r_scl_d0};
         if (start_det) begin
            bus_busy <= 1'b1;
         end else if (stop_det) begin
            bus_busy <= 1'b0;
         end
      end
   end

endmodule

// File: doc/i2c_pad_filter.md
Name: i2c_pad_filter

Overview:
Input front end for the I2C core: it conditions the raw SCL/SDA pad inputs.
- Synchronises both pad inputs into clk, removes spikes up to a programmable length, and presents clean line levels.
- Produces the single-cycle edge pulses and delayed edge pulses that the master/slave engines consume.
- Flags START/STOP conditions and tracks bus-busy for arbitration and slave wake-up.
- Sits between the pad cells and i2c_top.

Parameters:
SPK_W, 8, width of the spike-length register and the filter counters
SYNC_STAGES, 2, number of synchroniser flops per line (minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i2c_en  input  1  module enable (i2cm_en | i2cs_en)
i2c_spklen  input  SPK_W  maximum suppressed spike width, in clk cycles
scl_pad_in  input  1  raw SCL from pad, asynchronous
sda_pad_in  input  1  raw SDA from pad, asynchronous
i_scl_in  output  1  filtered SCL level
i_sda_in  output  1  filtered SDA level
f_scl  output  1  SCL falling-edge pulse
r_scl  output  1  SCL rising-edge pulse
f_sda  output  1  SDA falling-edge pulse
r_sda  output  1  SDA rising-edge pulse
f_scl_d  output  3  f_scl delayed by 1, 2, 3 cycles (bit n = n+1 cycles)
r_scl_d  output  2 [2:1]  r_scl delayed by 2 and 3 cycles (bit n = n+1 cycles)
start_det  output  1  pulse: SDA fell while SCL high
stop_det  output  1  pulse: SDA rose while SCL high
bus_busy  output  1  high from START until STOP

Behaviour:
Clock and reset
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: i_scl_in=1, i_sda_in=1, synchroniser flops=1, all pulse outputs and delay lines=0, bus_busy=0, counters=0.

Synchroniser
- SYNC_STAGES flops per line, each preset to 1.

Glitch filter (one per line)
- Holds filt (reset 1) and cnt.
- Synced value == filt: cnt <= 0.
- Synced value != filt and cnt >= i2c_spklen: filt <= synced value, cnt <= 0.
- Otherwise: cnt <= cnt+1.
- Result: a change must persist for i2c_spklen+1 consecutive cycles to propagate.
- i2c_spklen=0 gives pass-through after the synchroniser plus one cycle.
- Total latency from pad to output = SYNC_STAGES + i2c_spklen + 1 cycles.
- i2c_spklen lowered mid-count: the >= compare makes the filter commit on the next cycle.
- cnt never exceeds i2c_spklen, so no wrap occurs.
- i_scl_in and i_sda_in are the filt registers.

Edge detect
- prev_x holds filt from the previous cycle.
- f_x = prev_x & ~filt; r_x = ~prev_x & filt. These are combinational from registers.
- Each pulse is high exactly in the first cycle the new level is visible.
- Delay lines are registered shifts of f_scl/r_scl.

START/STOP detection
- start_det = f_sda & i_scl_in & prev_scl.
- stop_det = r_sda & i_scl_in & prev_scl.
- The filters commit independently. If SCL and SDA commit in the same cycle, SCL is not considered stably high, so no START/STOP fires.

bus_busy
- Set on start_det; cleared on stop_det.
- A repeated START keeps it high.
- Both in the same cycle is impossible by construction.

Disable
- i2c_en=0: filters forced to 1, cnt cleared, delay lines cleared, bus_busy cleared, no pulses.
- Synchronisers keep running.
- On re-enable, a line already low is seen as a falling edge after the filter delay. No START is reported unless SCL is high.

Decomposition:
- Package i2c_pkg holds: SPK_W, SYNC_STAGES default, and the idle line level constant (1).
- Sub-module i2c_glitch_filt covers one line: synchroniser, counter, filt register, and edge pulses. It is instantiated twice, for SCL and SDA.
- The top level adds the delay lines, START/STOP logic and bus_busy.

Test Plan:
1. Reset then idle: hold both pads at 1, deassert rst_n → i_scl_in=i_sda_in=1, all pulses 0, bus_busy=0 for 50 cycles.
2. Spike rejection: spklen=4, SDA low for 4 cycles → no change on i_sda_in. SDA low for 5 cycles → i_sda_in falls 2+5 cycles after the pad edge, with f_sda high for 1 cycle.
3. START/STOP: spklen=2, SCL=1, SDA 1→0 → start_det 1 cycle and bus_busy=1. Then SDA 0→1 with SCL=1 → stop_det 1 cycle and bus_busy=0.
4. Delayed edges: SCL 1→0 then 0→1, spklen=0 → f_scl at cycle T, f_scl_d[0..2] at T+1..T+3. r_scl at cycle U, r_scl_d[1] at U+2, r_scl_d[2] at U+3.
5. Simultaneous commit: spklen=0, SCL and SDA both fall in the same pad cycle → f_scl and f_sda pulse together, start_det=0.
6. Disable mid-transfer: bus_busy=1, drop i2c_en → outputs return to 1 and bus_busy=0 next cycle. Assert rst_n low mid-count → immediate return to reset values.
